// File: rtl/spec_dep_pkg.sv
// Shared types and helpers for the speculative-branch dependency tracker.
package spec_dep_pkg;

    localparam int unsigned DEF_NTAG    = 5;
    localparam int unsigned DEF_ALLOC_W = 2;
    localparam int unsigned DEF_RES_W   = 1;
    localparam int unsigned MAX_NTAG    = 32;
    localparam int unsigned IDX_W       = $clog2(MAX_NTAG);

    typedef logic [MAX_NTAG-1:0] spectag_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input spectag_t tag);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NTAG; i++) begin
            if (tag[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [31:0] popcount(input spectag_t tag);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_NTAG; i++) begin
            cnt = cnt + {31'd0, tag[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/spec_dep_row.sv
// One dependency row: which tags this tag depends on (itself and older in-flight tags).
module spec_dep_row
    import spec_dep_pkg::*;
#(
    parameter int unsigned NTAG = DEF_NTAG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc,
    input  logic [NTAG-1:0] alloc_deps,
    input  logic            clear,
    input  logic [NTAG-1:0] col_clear,
    output logic [NTAG-1:0] dep
);

    always_ff @(posedge clk) begin
        if (reset) begin
            dep <= '0;
        end else if (clear) begin
            dep <= '0;
        end else if (alloc) begin
            dep <= alloc_deps;
        end else begin
            dep <= dep & ~col_clear;
        end
    end

endmodule

// File: rtl/spec_dep_tracker.sv
// Speculative-branch dependency tracker with selective squash.
// Define SPEC_DEP_STATS_EN to build the alloc/miss/squash event counters.
module spec_dep_tracker
    import spec_dep_pkg::*;
#(
    parameter int unsigned NTAG    = DEF_NTAG,
    parameter int unsigned ALLOC_W = DEF_ALLOC_W,
    parameter int unsigned RES_W   = DEF_RES_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ALLOC_W-1:0]      alloc_en,
    input  logic [ALLOC_W*NTAG-1:0] alloc_tag,
    input  logic [RES_W-1:0]        res_valid,
    input  logic [RES_W-1:0]        res_miss,
    input  logic [RES_W*NTAG-1:0]   res_tag,
    input  logic [NTAG-1:0]         query_tag,
    output logic [NTAG-1:0]         query_mask,
    output logic [NTAG-1:0]         valid_mask,
    output logic                    kill_valid,
    output logic [NTAG-1:0]         kill_mask,
    output logic [31:0]             stat_alloc,
    output logic [31:0]             stat_miss,
    output logic [31:0]             stat_squash
);

    logic [NTAG-1:0] valid_q, valid_d;
    logic            kill_valid_q;
    logic [NTAG-1:0] kill_mask_q;
    logic [NTAG-1:0] dep [NTAG];

    logic [NTAG-1:0] succ, miss, succ_eff, kill, valid_eff;
    logic [NTAG-1:0] alloc_set, prior, slot_tag;
    logic [NTAG-1:0] row_deps [NTAG];
    logic            any_miss;

    always_comb begin
        succ = '0;
        miss = '0;
        for (int j = 0; j < RES_W; j++) begin
            if (res_valid[j]) begin
                if (res_miss[j]) miss = miss | res_tag[j*NTAG +: NTAG];
                else             succ = succ | res_tag[j*NTAG +: NTAG];
            end
        end
        // A tag reported both ways in one cycle is treated as a miss.
        succ_eff  = succ & ~miss;
        any_miss  = |miss;
        valid_eff = valid_q & ~succ_eff;
        for (int k = 0; k < NTAG; k++) begin
            kill[k] = valid_q[k] & |(dep[k] & miss);
        end
    end

    // Allocations are dropped whenever a miss redirects the front end.
    always_comb begin
        alloc_set = '0;
        prior     = '0;
        slot_tag  = '0;
        for (int k = 0; k < NTAG; k++) row_deps[k] = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            slot_tag = alloc_tag[i*NTAG +: NTAG];
            if (alloc_en[i] && !any_miss) begin
                for (int k = 0; k < NTAG; k++) begin
                    if (slot_tag[k]) row_deps[k] = valid_eff | prior | slot_tag;
                end
                alloc_set = alloc_set | slot_tag;
                prior     = prior | slot_tag;
            end
        end
        valid_d = (valid_q & ~succ_eff & ~kill) | alloc_set;
    end

    for (genvar g = 0; g < NTAG; g++) begin : g_row
        spec_dep_row #(
            .NTAG (NTAG)
        ) u_row (
            .clk        (clk),
            .reset      (reset),
            .alloc      (alloc_set[g]),
            .alloc_deps (row_deps[g]),
            .clear      (kill[g] | succ_eff[g]),
            .col_clear  (succ_eff),
            .dep        (dep[g])
        );
    end

    always_comb begin
        query_mask = '0;
        for (int k = 0; k < NTAG; k++) begin
            query_mask[k] = |(dep[k] & query_tag);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            kill_valid_q <= 1'b0;
            kill_mask_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            kill_valid_q <= |kill;
            kill_mask_q  <= kill;
        end
    end

    assign valid_mask = valid_q;
    assign kill_valid = kill_valid_q;
    assign kill_mask  = kill_mask_q;

`ifdef SPEC_DEP_STATS_EN
    logic [31:0] stat_alloc_q, stat_miss_q, stat_squash_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_alloc_q  <= '0;
            stat_miss_q   <= '0;
            stat_squash_q <= '0;
        end else begin
            stat_alloc_q  <= stat_alloc_q + popcount(spectag_t'(alloc_set));
            stat_miss_q   <= stat_miss_q + popcount(spectag_t'(res_valid & res_miss));
            stat_squash_q <= stat_squash_q + popcount(spectag_t'(kill));
        end
    end

    assign stat_alloc  = stat_alloc_q;
    assign stat_miss   = stat_miss_q;
    assign stat_squash = stat_squash_q;
`else
    assign stat_alloc  = '0;
    assign stat_miss   = '0;
    assign stat_squash = '0;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ALLOC_W; i++) begin
                if (alloc_en[i]) begin
                    assert ($onehot(alloc_tag[i*NTAG +: NTAG]))
                        else $error("alloc slot %0d tag not one-hot", i);
                    assert ((alloc_tag[i*NTAG +: NTAG] & valid_eff) == '0)
                        else $error("alloc of in-flight tag %0d",
                                    onehot_to_idx(spectag_t'(alloc_tag[i*NTAG +: NTAG])));
                    for (int j = i + 1; j < ALLOC_W; j++) begin
                        assert (!(alloc_en[j] &&
                                  alloc_tag[i*NTAG +: NTAG] == alloc_tag[j*NTAG +: NTAG]))
                            else $error("alloc slots %0d and %0d share a tag", i, j);
                    end
                end
            end
            for (int j = 0; j < RES_W; j++) begin
                if (res_valid[j]) begin
                    assert ($onehot(res_tag[j*NTAG +: NTAG]))
                        else $error("resolve %0d tag not one-hot", j);
                    assert ((res_tag[j*NTAG +: NTAG] & ~valid_q) == '0)
                        else $error("resolve of idle tag %0d",
                                    onehot_to_idx(spectag_t'(res_tag[j*NTAG +: NTAG])));
                end
            end
        end
    end
`endif

endmodule
